uart_reg_writer: RTL
====================

# uart_reg_writer

Writer-side agent for the register file's UART write path. It accepts a load request from the core naming a destination register and bank, collects four bytes from the UART receiver and assembles them into one 32-bit word. It then issues exactly one write into the integer or float bank using the register file's toggle-deduplicated write protocol. It sits between the UART RX byte stream and the register file write port (`rw`, `write_data`, `AorF_before`, `UART_write_enable`, `distinct`).

## Interface
Parameters:
- `BIG_ENDIAN`, default 1: 1 = first received byte lands in [31:24]; 0 = first byte lands in [7:0].
- `TIMEOUT`, default 0: maximum idle cycles allowed between accepted bytes while in RECV; 0 disables the timeout.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting it (low) resets all state immediately.
- `req`  in  1  one-cycle load request from core; sampled only in IDLE.
- `req_rd`  in  5  destination register index, latched with `req`.
- `req_float`  in  1  bank select latched with `req`: 1 = float bank, 0 = integer bank.
- `rx_valid`  in  1  UART byte available.
- `rx_data`  in  8  UART byte.
- `rx_ready`  out  1  block accepts a byte this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the write is issued.
- `err`  out  1  one-cycle pulse on timeout abort.
- `rw`  out  5  register file write index.
- `write_data`  out  32  register file write data.
- `AorF_before`  out  1  register file bank select for the write.
- `UART_write_enable`  out  1  register file write strobe.
- `distinct`  out  1  write token; it toggles once per issued write.

## Operation
- States are IDLE, RECV, WRITE and DONE. A 2-bit byte counter `cnt` tracks received bytes; a timeout counter of width clog2(TIMEOUT+1) is present when TIMEOUT>0.
- **IDLE:**
  - On `req`=1, latch `req_rd` into `rw` and `req_float` into `AorF_before`.
  - Clear `cnt` and clear the assembly register, then go to RECV.
  - Any `req` seen outside IDLE is ignored.
- **RECV:**
  - `rx_ready`=1. A byte is accepted on each edge where `rx_valid`=1.
  - Byte k (k=0..3) is placed at bits [31-8k:24-8k] when BIG_ENDIAN=1, or at bits [8k+7:8k] otherwise.
  - `cnt` increments modulo 4. Accepting the byte at `cnt`=3 moves the block to WRITE.
  - If TIMEOUT>0, the timeout counter clears on every accepted byte and increments on every other RECV cycle. When it reaches TIMEOUT, the block goes to IDLE, pulses `err` and issues no write. A partial word is discarded.
- **WRITE:**
  - Exactly one cycle long.
  - `UART_write_enable`=1 and `write_data` holds the assembled word.
  - `distinct` was toggled on the edge that entered WRITE, so it differs from the register file's last-recorded token.
  - Next state is DONE.
- **DONE:** `done`=1 for one cycle, then the block returns to IDLE.
- `rw`, `AorF_before` and `write_data` hold their values from the WRITE cycle until the next `req` is latched.
- `distinct` resets to 1. This matches the register file's token reset value, so no spurious write occurs after reset.

## Timing
- Reset values: state=IDLE, `cnt`=0, `rx_ready`=0, `busy`=0, `done`=0, `err`=0, `rw`=0, `write_data`=0, `AorF_before`=0, `UART_write_enable`=0, `distinct`=1.
- `rx_ready` and `UART_write_enable` are registered state decodes; they have no combinational path from `rx_valid` or `req`.
- Latency:
  - `req` edge → `rx_ready` high in the next cycle.
  - 4th-byte accept edge → `UART_write_enable` high in the following cycle.
  - `done` is high in the cycle after that.
  - Minimum `req`-to-`done` span is 6 cycles when bytes arrive back-to-back.
- `rx_valid` while not in RECV: the byte is not consumed (`rx_ready`=0), and the UART holds it.
- `req` in the same cycle as the DONE→IDLE transition: ignored, because the block is not yet in IDLE. `req` is accepted from the first IDLE cycle.
- `UART_write_enable` is never high for more than one cycle per request, and `distinct` toggles exactly once per write.
- Reset asserted mid-RECV or mid-WRITE: all outputs return to their reset values asynchronously, `distinct` returns to 1, and the pending word is lost.

## Test plan
- Reset, then `req` with `req_rd`=5, `req_float`=0, then bytes 0x12,0x34,0x56,0x78 back-to-back (BIG_ENDIAN=1) -> one WRITE cycle with `rw`=5, `write_data`=0x12345678, `AorF_before`=0, `distinct` 1→0; `done` pulses; integer register 5 = 0x12345678.
- Two consecutive loads to float registers 3 and 4 with data 0x3F800000 and 0x40000000 -> `distinct` toggles 0→1, then 1→0; both float registers are written, each exactly once.
- BIG_ENDIAN=0, bytes 0x78,0x56,0x34,0x12 -> `write_data`=0x12345678.
- Bytes with `rx_valid` gaps of 1–7 cycles, plus a `req` pulse during RECV -> still exactly one write with correct data; the extra `req` is ignored and `rw` is unchanged.
- TIMEOUT=16, two bytes then silence -> `err` pulses 16 cycles after the second byte; no `UART_write_enable`; `distinct` unchanged; a following request completes normally.
- `reset` driven low during the 3rd byte, then released -> outputs at reset values, `distinct`=1, no register file write; a new request then succeeds.

Source files
------------

// File: rtl/uart_reg_writer.sv
// uart_reg_writer: collects four UART RX bytes after a core load request,
// assembles them into a 32-bit word and issues exactly one register file write.
// Ports:
//   CLK, reset        - rising-edge clock, asynchronous active-low reset
//   req/req_rd/req_float - load request with destination index and bank (sampled in IDLE only)
//   rx_valid/rx_data/rx_ready - UART byte stream handshake (byte taken when both high)
//   busy/done/err     - status: not idle / one-cycle completion / one-cycle timeout abort
//   rw/write_data/AorF_before/UART_write_enable/distinct - register file write port;
//   distinct is a token that flips once per issued write so the register file
//   can tell a fresh write from a stale strobe.
module uart_reg_writer #(
  parameter int BIG_ENDIAN = 1,  // 1: first byte -> [31:24]; 0: first byte -> [7:0]
  parameter int TIMEOUT    = 0   // max idle RECV cycles between bytes; 0 disables
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  req_rd,
  input  logic        req_float,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  rw,
  output logic [31:0] write_data,
  output logic        AorF_before,
  output logic        UART_write_enable,
  output logic        distinct
);

  // Timeout counter width; kept at one bit when the timeout is disabled so the
  // declaration stays legal. The counter is never advanced in that case.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic [TW-1:0] tcnt_q;
  logic [31:0]   data_q;
  logic [31:0]   data_d;
  logic [4:0]    rw_q;
  logic          aorf_q;
  logic          rx_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          wen_q;
  logic          distinct_q;
  logic          timeout_hit;

  // The assembly register is cleared at request time, so shifting each byte in
  // from one end places byte k exactly where its index dictates once all four
  // have arrived: shifting left leaves byte 0 in [31:24], shifting right leaves
  // byte 0 in [7:0].
  always_comb begin
    data_d = data_q;
    if (BIG_ENDIAN != 0) begin
      data_d = {data_q[23:0], rx_data};
    end else begin
      data_d = {rx_data, data_q[31:8]};
    end
  end

  // The counter holds the number of idle cycles already seen; the idle cycle
  // that would bring it to TIMEOUT is the one that aborts.
  assign timeout_hit = (TIMEOUT > 0) && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      tcnt_q     <= '0;
      data_q     <= 32'd0;
      rw_q       <= 5'd0;
      aorf_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wen_q      <= 1'b0;
      // Matches the register file's token reset value: no phantom write.
      distinct_q <= 1'b1;
    end else begin
      // Pulse outputs default low; they are raised only on the edge entering
      // the state they decode.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wen_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req) begin
            rw_q       <= req_rd;
            aorf_q     <= req_float;
            cnt_q      <= 2'd0;
            tcnt_q     <= '0;
            data_q     <= 32'd0;
            state_q    <= RECV;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        RECV: begin
          if (rx_valid) begin
            data_q <= data_d;
            cnt_q  <= cnt_q + 2'd1;
            tcnt_q <= '0;
            if (cnt_q == 2'd3) begin
              state_q    <= WRITE;
              rx_ready_q <= 1'b0;
              wen_q      <= 1'b1;
              // Flip the token on the same edge that raises the strobe so the
              // register file sees a new token for this write only.
              distinct_q <= ~distinct_q;
            end
          end else if (timeout_hit) begin
            // Abort: drop the partial word and return without writing.
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            cnt_q      <= 2'd0;
            tcnt_q     <= '0;
            data_q     <= 32'd0;
          end else if (TIMEOUT > 0) begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end

        DONE: begin
          // A req arriving now is sampled outside IDLE and therefore dropped.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= IDLE;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready          = rx_ready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign rw                = rw_q;
  assign write_data        = data_q;
  assign AorF_before       = aorf_q;
  assign UART_write_enable = wen_q;
  assign distinct          = distinct_q;

endmodule
